io_bridge: RTL and testbench

IO_BRIDGE -- requirements
Module: io_bridge

---
 rtl/io_bridge_pkg.sv | 22 ++
 rtl/io_wbuf.sv | 51 +++++
 rtl/io_bridge.sv | 150 +++++++++++++++
 tb/tb_io_bridge.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_bridge_pkg.sv
// Shared constants and types for the CPU-side IO bridge: address map, error
// register location and the GPIO drain-state encoding.
package io_bridge_pkg;

    localparam logic [31:0] RAM_LIMIT         = 32'h0001_0000;
    localparam logic [31:0] GPIO_BASE_DEFAULT = 32'h0001_0000;
    // Error register sits in the 16-byte window just above the GPIO window.
    localparam logic [3:0]  ERR_OFFSET        = 4'h0;
    localparam int          WBUF_WIDTH        = 36;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        GAP    = 2'd2
    } drain_state_e;

    function automatic logic [WBUF_WIDTH-1:0] pack_entry(input logic [3:0] addr,
                                                         input logic [31:0] data);
        return {addr, data};
    endfunction

endpackage

// File: rtl/io_wbuf.sv
// Posted-write FIFO for the GPIO path: power-of-two depth, combinational head,
// caller guarantees no push when full and no pop when empty.
module io_wbuf #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 36,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CW-1:0]    count_o
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + CW'(1);
        end else if (!push_i && pop_i) begin
            count_d = count_q - CW'(1);
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push_i) mem[wr_ptr_q] <= wdata_i;
    end

    assign head_o  = mem[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/io_bridge.sv
// CPU data-port bridge: RAM pass-through plus a posted, rate-limited GPIO write
// path. Define IO_BRIDGE_ERR_EN to add the unmapped-access error register.
module io_bridge
    import io_bridge_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter int          DRAIN_GAP = 2,
    parameter logic [31:0] GPIO_BASE = GPIO_BASE_DEFAULT
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_we,
    input  logic        cpu_re,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic [31:0] A_DMEM,
    output logic [31:0] Di_DMEM,
    output logic        wmem_dmem,
    input  logic [31:0] Do_DMEM,
    output logic [31:0] A_GPIO,
    output logic [31:0] Di,
    output logic        wmem,
    input  logic [31:0] Do_Gpio
);
    localparam int CW = $clog2(DEPTH) + 1;

    drain_state_e         state_q, state_d;
    logic [3:0]           gap_q, gap_d;
    logic [3:0]           a_gpio_q, a_gpio_d;
    logic [31:0]          di_q, di_d;
    logic [CW-1:0]        count;
    logic [WBUF_WIDTH-1:0] head;
    logic                 pop, load;

    logic is_ram, is_gpio, wr_req, rd_req, full, busy, push, gpio_rd_ok;
    logic [31:0] err_rdata;

    assign is_ram     = cpu_addr < RAM_LIMIT;
    assign is_gpio    = cpu_addr[31:4] == GPIO_BASE[31:4];
    assign wr_req     = cpu_we;
    assign rd_req     = cpu_re & ~cpu_we;
    assign full       = count == CW'(DEPTH);
    assign busy       = (count != '0) || (state_q != IDLE);
    assign push       = is_gpio & wr_req & ~full;
    assign gpio_rd_ok = is_gpio & rd_req & ~busy;
    // A GPIO read must observe every earlier posted write, so it waits for a full drain.
    assign cpu_stall  = (is_gpio & wr_req & full) | (is_gpio & rd_req & busy);

    assign A_DMEM    = cpu_addr;
    assign Di_DMEM   = cpu_wdata;
    assign wmem_dmem = cpu_we & is_ram;

    io_wbuf #(.DEPTH(DEPTH), .WIDTH(WBUF_WIDTH), .CW(CW)) u_wbuf (
        .CLK     (CLK),
        .RESET   (RESET),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (pack_entry(cpu_addr[3:0], cpu_wdata)),
        .head_o  (head),
        .count_o (count)
    );

    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        a_gpio_d = a_gpio_q;
        di_d     = di_q;
        load     = 1'b0;
        pop      = 1'b0;
        case (state_q)
            IDLE: begin
                if (count != '0) load = 1'b1;
            end
            STROBE: begin
                pop = 1'b1;
                if (DRAIN_GAP == 0) begin
                    state_d = IDLE;
                end else begin
                    state_d = GAP;
                    gap_d   = 4'(DRAIN_GAP - 1);
                end
            end
            GAP: begin
                // Last gap cycle hands straight to the next strobe so the idle span is exact.
                if (gap_q != 4'd0)      gap_d   = gap_q - 4'd1;
                else if (count != '0)   load    = 1'b1;
                else                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            state_d  = STROBE;
            a_gpio_d = head[35:32];
            di_d     = head[31:0];
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= IDLE;
            gap_q    <= 4'd0;
            a_gpio_q <= 4'd0;
            di_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            a_gpio_q <= a_gpio_d;
            di_q     <= di_d;
        end
    end

    assign wmem   = state_q == STROBE;
    assign Di     = di_q;
    assign A_GPIO = gpio_rd_ok ? {28'h0, cpu_addr[3:0]} : {28'h0, a_gpio_q};

`ifdef IO_BRIDGE_ERR_EN
    localparam logic [31:0] ERR_ADDR = {GPIO_BASE[31:4] + 28'h1, ERR_OFFSET};
    logic        is_err, unmapped;
    logic [31:0] err_q;

    assign is_err   = cpu_addr == ERR_ADDR;
    assign unmapped = (cpu_we | cpu_re) & ~is_ram & ~is_gpio & ~is_err;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            err_q <= 32'd0;
        end else if (is_err && wr_req) begin
            err_q <= 32'd0;
        end else if (unmapped && !err_q[0]) begin
            err_q <= {cpu_addr[31:1], 1'b1};
        end
    end

    assign err_rdata = (is_err && rd_req) ? err_q : 32'd0;
`else
    assign err_rdata = 32'd0;
`endif

    always_comb begin
        cpu_rdata = 32'd0;
        if (rd_req) begin
            if (is_ram)          cpu_rdata = Do_DMEM;
            else if (gpio_rd_ok) cpu_rdata = Do_Gpio;
            else                 cpu_rdata = err_rdata;
        end
    end

endmodule

// File: tb/tb_io_bridge.sv
// Randomized and directed bench for io_bridge against a queue-based model of
// the posted GPIO write path and the address map.
module tb_io_bridge;
    localparam int          DEPTH     = 4;
    localparam int          DRAIN_GAP = 2;
    localparam logic [31:0] GPIO_BASE = 32'h0001_0000;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [31:0] cpu_addr = 32'd0, cpu_wdata = 32'd0;
    logic        cpu_we = 1'b0, cpu_re = 1'b0;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic [31:0] A_DMEM, Di_DMEM;
    logic        wmem_dmem;
    logic [31:0] Do_DMEM = 32'd0;
    logic [31:0] A_GPIO, Di;
    logic        wmem;
    logic [31:0] Do_Gpio;

    io_bridge #(.DEPTH(DEPTH), .DRAIN_GAP(DRAIN_GAP), .GPIO_BASE(GPIO_BASE)) dut (
        .CLK(CLK), .RESET(RESET),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_re(cpu_re),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .A_DMEM(A_DMEM), .Di_DMEM(Di_DMEM), .wmem_dmem(wmem_dmem), .Do_DMEM(Do_DMEM),
        .A_GPIO(A_GPIO), .Di(Di), .wmem(wmem), .Do_Gpio(Do_Gpio)
    );

    always #5 CLK = ~CLK;

    // GPIO peripheral stub: a 16-word register file written by strobes.
    logic [31:0] periph [16];
    initial for (int i = 0; i < 16; i++) periph[i] = 32'd0;
    always @(posedge CLK) if (wmem) periph[A_GPIO[3:0]] <= Di;
    assign Do_Gpio = periph[A_GPIO[3:0]];

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [35:0] exp_q [$];
    logic [31:0] ref_gpio [16];
    int          pending = 0;
    int          since = 1000;
    int          cyc = 0;
    int          stall_cycles = 0;
    int          pulse_cyc [$];
    logic        err_valid = 1'b0;
    logic [31:0] err_addr = 32'd0;

    logic        s_wmem, s_stall, s_we, s_re, s_wmem_dmem;
    logic [31:0] s_addr, s_wdata, s_rdata;

    function automatic logic is_ram_f(input logic [31:0] a);
        return a < 32'h0001_0000;
    endfunction

    function automatic logic is_gpio_f(input logic [31:0] a);
        logic [31:0] b;
        b = GPIO_BASE;
        return a[31:4] == b[31:4];
    endfunction

    function automatic logic is_err_f(input logic [31:0] a);
`ifdef IO_BRIDGE_ERR_EN
        return a == GPIO_BASE + 32'h10;
`else
        return (a == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    task automatic sample_and_check();
        logic        wr, rd, gp, exp_stall;
        logic [31:0] exp_rd;
        logic [35:0] e;
        wr = cpu_we;
        rd = cpu_re && !cpu_we;
        gp = is_gpio_f(cpu_addr);
        s_wmem = wmem; s_stall = cpu_stall; s_addr = cpu_addr; s_wdata = cpu_wdata;
        s_we = cpu_we; s_re = cpu_re; s_rdata = cpu_rdata; s_wmem_dmem = wmem_dmem;

        if (wmem) begin
            check("strobe_spacing", 32'(since > DRAIN_GAP), 32'd1);
            if (exp_q.size() == 0) begin
                check("strobe_extra", 32'(wmem), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("strobe_addr", A_GPIO, {28'h0, e[35:32]});
                check("strobe_data", Di, e[31:0]);
                ref_gpio[e[35:32]] = e[31:0];
                pulse_cyc.push_back(cyc);
                $display("strobe cyc=%0d addr=%h data=%h", cyc, e[35:32], e[31:0]);
            end
        end
        check("wmem_dmem", 32'(wmem_dmem), 32'(wr && is_ram_f(cpu_addr)));
        check("A_DMEM", A_DMEM, cpu_addr);
        check("Di_DMEM", Di_DMEM, cpu_wdata);

        exp_stall = 1'b0;
        if (gp && wr)      exp_stall = (pending == DEPTH);
        else if (gp && rd) exp_stall = (pending > 0) || (since >= 1 && since <= DRAIN_GAP);
        check("stall", 32'(cpu_stall), 32'(exp_stall));

        if (!cpu_re) begin
            check("rdata_idle", cpu_rdata, 32'd0);
        end else if (rd && !exp_stall) begin
            if (is_ram_f(cpu_addr))      exp_rd = Do_DMEM;
            else if (gp)                 exp_rd = ref_gpio[cpu_addr[3:0]];
            else if (is_err_f(cpu_addr)) exp_rd = {err_addr[31:1], err_valid};
            else                         exp_rd = 32'd0;
            check("rdata", cpu_rdata, exp_rd);
            if (gp) check("A_GPIO_rd", A_GPIO, {28'h0, cpu_addr[3:0]});
        end
        if (cpu_stall) stall_cycles++;
    endtask

    task automatic update_model();
        if (is_gpio_f(s_addr) && s_we && !s_stall) begin
            exp_q.push_back({s_addr[3:0], s_wdata});
            pending++;
        end
        if (s_wmem) pending--;
        since = s_wmem ? 1 : ((since < 1000) ? since + 1 : since);
`ifdef IO_BRIDGE_ERR_EN
        if (is_err_f(s_addr) && s_we) begin
            err_valid = 1'b0;
            err_addr  = 32'd0;
        end else if ((s_we || s_re) && !is_ram_f(s_addr) && !is_gpio_f(s_addr)
                     && !is_err_f(s_addr) && !err_valid) begin
            err_valid = 1'b1;
            err_addr  = s_addr;
        end
`endif
        cyc++;
    endtask

    task automatic step();
        @(negedge CLK);
        sample_and_check();
        @(posedge CLK);
        update_model();
        #1;
    endtask

    task automatic set_req(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
        cpu_we = we; cpu_re = re; cpu_addr = a; cpu_wdata = d;
    endtask

    // Issue one request and hold it until it is accepted (bounded).
    task automatic do_req(input logic we, input logic re, input logic [31:0] a,
                          input logic [31:0] d, input int max_cycles);
        set_req(we, re, a, d);
        for (int n = 0; n < max_cycles; n++) begin
            step();
            if (!s_stall) break;
        end
        if (s_stall) check("req_timeout", 32'd1, 32'd0);
        $display("req we=%0b re=%0b addr=%08h wdata=%08h rdata=%08h", we, re, a, d, s_rdata);
    endtask

    task automatic idle_steps(input int n);
        set_req(1'b0, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, st0, kind;
        int exp_off [3];
        logic [31:0] a;
        exp_off = '{1, 4, 7};
        for (int i = 0; i < 16; i++) ref_gpio[i] = 32'd0;

        // Reset state
        set_req(1'b1, 1'b0, GPIO_BASE, 32'h1234_5678);
        #2;
        check("rst_wmem", 32'(wmem), 32'd0);
        check("rst_stall", 32'(cpu_stall), 32'd0);
        check("rst_Di", Di, 32'd0);
        set_req(1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        check("rst_A_GPIO", A_GPIO, 32'd0);
        check("rst_rdata", cpu_rdata, 32'd0);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK); #1;
        idle_steps(3);

        // Three back-to-back GPIO writes: strobes 1, 4, 7 cycles after first push
        pulse_cyc.delete();
        st0 = stall_cycles;
        c0 = cyc;
        do_req(1'b1, 1'b0, GPIO_BASE + 32'h0, 32'h0F, 10);
        do_req(1'b1, 1'b0, GPIO_BASE + 32'h1, 32'h05, 10);
        do_req(1'b1, 1'b0, GPIO_BASE + 32'h2, 32'h0A, 10);
        idle_steps(12);
        check("t31_stalls", 32'(stall_cycles - st0), 32'd0);
        check("t31_pulses", 32'(pulse_cyc.size()), 32'd3);
        for (int i = 0; i < 3 && i < pulse_cyc.size(); i++)
            check("t31_offset", 32'(pulse_cyc[i] - c0 - 1), 32'(exp_off[i]));

        // Six back-to-back writes into a 4-deep buffer
        pulse_cyc.delete();
        st0 = stall_cycles;
        for (int i = 0; i < 6; i++)
            do_req(1'b1, 1'b0, GPIO_BASE + 32'(i + 4), $urandom, 30);
        set_req(1'b0, 1'b0, 32'd0, 32'd0);
        for (int n = 0; n < 60 && pending > 0; n++) step();
        idle_steps(4);
        check("t32_stall_seen", 32'(stall_cycles > st0), 32'd1);
        check("t32_pulses", 32'(pulse_cyc.size()), 32'd6);
        check("t32_count", 32'(pending), 32'd0);

        // Write then immediate read of the same GPIO register
        do_req(1'b1, 1'b0, GPIO_BASE + 32'h1, 32'h07, 10);
        st0 = stall_cycles;
        do_req(1'b0, 1'b1, GPIO_BASE + 32'h1, 32'd0, 30);
        check("t33_stalled", 32'(stall_cycles > st0), 32'd1);
        check("t33_rdata", s_rdata, 32'h07);

        // RAM write pass-through
        Do_DMEM = 32'hCAFE_F00D;
        set_req(1'b1, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF);
        step();
        check("t34_wmem_dmem", 32'(s_wmem_dmem), 32'd1);
        check("t34_stall", 32'(s_stall), 32'd0);
        check("t34_wmem", 32'(s_wmem), 32'd0);
        $display("req ram write addr=00000100 data=deadbeef");

        // Unmapped read and error register
        set_req(1'b0, 1'b1, 32'h0002_0000, 32'd0);
        step();
        check("t35_rdata", s_rdata, 32'd0);
        check("t35_stall", 32'(s_stall), 32'd0);
        set_req(1'b0, 1'b1, GPIO_BASE + 32'h10, 32'd0);
        step();
`ifdef IO_BRIDGE_ERR_EN
        check("t35_err", s_rdata, 32'h0002_0001);
        set_req(1'b1, 1'b0, GPIO_BASE + 32'h10, 32'd0);
        step();
        set_req(1'b0, 1'b1, GPIO_BASE + 32'h10, 32'd0);
        step();
        check("t35_err_clr", s_rdata, 32'd0);
`else
        check("t35_err_unmapped", s_rdata, 32'd0);
`endif
        idle_steps(2);

        // Reset mid-drain with two entries pending in the gap
        pulse_cyc.delete();
        do_req(1'b1, 1'b0, GPIO_BASE + 32'h3, 32'h33, 10);
        do_req(1'b1, 1'b0, GPIO_BASE + 32'h4, 32'h44, 10);
        do_req(1'b1, 1'b0, GPIO_BASE + 32'h5, 32'h55, 10);
        set_req(1'b0, 1'b0, 32'd0, 32'd0);
        for (int n = 0; n < 10 && pulse_cyc.size() == 0; n++) step();
        check("t36_pending", 32'(pending), 32'd2);
        set_req(1'b0, 1'b1, GPIO_BASE + 32'h3, 32'd0);
        #1 RESET = 1'b0;
        #1;
        check("t36_wmem", 32'(wmem), 32'd0);
        check("t36_stall", 32'(cpu_stall), 32'd0);
        check("t36_Di", Di, 32'd0);
        set_req(1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        check("t36_A_GPIO", A_GPIO, 32'd0);
        exp_q.delete();
        pending = 0;
        since = 1000;
        pulse_cyc.delete();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK); #1;
        idle_steps(20);
        check("t36_no_strobe", 32'(pulse_cyc.size()), 32'd0);

        // Randomized mix, requests held while stalled
        for (int n = 0; n < 400; n++) begin
            if (!s_stall) begin
                kind = $urandom_range(0, 9);
                case (kind)
                    0, 1, 2, 3: a = $urandom & 32'h0000_FFFC;
                    4, 5, 6, 7: a = GPIO_BASE + 32'($urandom_range(0, 15));
                    8:          a = 32'h0002_0000 + 32'($urandom_range(0, 4095) << 4);
                    default:    a = GPIO_BASE + 32'h10;
                endcase
                case ($urandom_range(0, 3))
                    0:       set_req(1'b0, 1'b0, a, $urandom);
                    1:       set_req(1'b1, 1'b0, a, $urandom);
                    2:       set_req(1'b0, 1'b1, a, $urandom);
                    default: set_req(1'b1, 1'b1, a, $urandom);
                endcase
                Do_DMEM = $urandom;
            end
            step();
        end
        set_req(1'b0, 1'b0, 32'd0, 32'd0);
        for (int n = 0; n < 100 && (pending > 0 || since <= DRAIN_GAP); n++) step();
        check("final_count", 32'(pending), 32'd0);
        check("final_queue", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
